// File: rtl/pu_pkg.sv
// Shared definitions for the dot-product sequencer and its processing unit:
// the sequencer FSM state type and the FP32 constants used by the datapath.
package pu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/processor_unit.sv
// Combinational FP32 multiply-accumulate: out = previous + a0*b0 + a1*b1.
// Round-to-nearest-even on every operation; denormal inputs and results are
// flushed to signed zero; any NaN operand (or Inf*0, Inf-Inf) gives a quiet NaN.
module processor_unit
  import pu_pkg::*;
(
  input  logic [31:0] previous,
  input  logic [31:0] array1_0,
  input  logic [31:0] array1_1,
  input  logic [31:0] array2_0,
  input  logic [31:0] array2_1,
  output logic [31:0] out
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] prod;
    logic [24:0] mant;
    logic        g;
    logic        st;
    int          e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
      return FP_QNAN;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? FP_QNAN : {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
      return {s, 31'h0};
    prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    // Product of two [1,2) mantissas lies in [1,4): normalise by at most one bit.
    if (prod[47]) begin
      mant = {1'b0, prod[47:24]};
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 1;
    end else begin
      mant = {1'b0, prod[46:23]};
      g    = prod[22];
      st   = |prod[21:0];
    end
    if (g && (st || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a;
    logic [31:0] b;
    logic [26:0] ma;
    logic [26:0] mb;
    logic [53:0] sh;
    logic [27:0] sum;
    logic [24:0] mant;
    logic        found;
    int          d;
    int          e;
    int          lz;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != '0) return FP_QNAN;
      if (y[30:23] == 8'hFF) return (y[22:0] != '0 || y[31] != x[31]) ? FP_QNAN : x;
      return x;
    end
    if (y[30:23] == 8'hFF) return (y[22:0] != '0) ? FP_QNAN : y;
    if (y[30:23] == 8'h00) return (x[30:23] == 8'h00) ? {x[31] & y[31], 31'h0} : x;
    if (x[30:23] == 8'h00) return y;
    // Order by magnitude so the subtract path never goes negative.
    if (x[30:0] >= y[30:0]) begin
      a = x;
      b = y;
    end else begin
      a = y;
      b = x;
    end
    d = int'(a[30:23]) - int'(b[30:23]);
    if (d > 27) d = 27;  // beyond this only the sticky bit survives
    e  = int'(a[30:23]);
    ma = {1'b1, a[22:0], 3'b000};
    sh = {1'b1, b[22:0], 3'b000, 27'h0} >> d;
    mb = {sh[53:28], sh[27] | (|sh[26:0])};
    if (a[31] == b[31]) begin
      sum = {1'b0, ma} + {1'b0, mb};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 1;
      end
    end else begin
      sum = {1'b0, ma} - {1'b0, mb};
      if (sum == '0) return FP_ZERO;
      lz    = 0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = 26 - i;
          found = 1'b1;
        end
      end
      sum = sum << lz;
      e   = e - lz;
    end
    mant = {1'b0, sum[26:3]};
    if (sum[2] && ((|sum[1:0]) || sum[3])) mant = mant + 25'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {a[31], 8'hFF, 23'h0};
    if (e <= 0)   return {a[31], 31'h0};
    return {a[31], e[7:0], mant[22:0]};
  endfunction

  // Accumulate the running value with both element products, in that order.
  always_comb begin
    out = fp_add(fp_add(previous, fp_mul(array1_0, array2_0)), fp_mul(array1_1, array2_1));
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: accepts a job (start/len), streams len operand beats
// through processor_unit feeding the running sum back as 'previous', then
// presents the FP32 result on a valid/ready port until it is taken.
// Optional build macro DPS_INIT_EN adds init_acc to seed the accumulator
// (bias / partial-sum chaining); without it the seed is +0.0.
module dot_product_sequencer
  import pu_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef DPS_INIT_EN
  input  logic [DW-1:0]    init_acc,
`endif
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a0,
  input  logic [DW-1:0]    in_a1,
  input  logic [DW-1:0]    in_b0,
  input  logic [DW-1:0]    in_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [DW-1:0]    seed;
  logic [DW-1:0]    pu_out;

`ifdef DPS_INIT_EN
  assign seed = init_acc;
`else
  assign seed = FP_ZERO;
`endif

  processor_unit u_pu (
    .previous (acc_q),
    .array1_0 (in_a0),
    .array1_1 (in_a1),
    .array2_0 (in_b0),
    .array2_1 (in_b1),
    .out      (pu_out)
  );

  // State, beat counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= FP_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic: start only in IDLE, one beat per accepted handshake in RUN,
  // result handshake in DONE (a start in DONE is deliberately dropped).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = seed;
          if (len != '0) begin
            state_d = ST_RUN;
            cnt_d   = len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          acc_d = pu_out;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_RUN);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = acc_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Testbench for dot_product_sequencer: table-driven single-beat jobs, directed
// multi-cycle sequences, and randomized jobs against an integer reference model.
module tb_dot_product_sequencer;
  import pu_pkg::*;

  localparam int LEN_W = 16;
  localparam int DW    = 32;
`ifdef DPS_INIT_EN
  localparam bit HAS_INIT = 1'b1;
`else
  localparam bit HAS_INIT = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic [LEN_W-1:0] len       = '0;
  logic [DW-1:0]    init_acc  = '0;
  logic             in_valid  = 1'b0;
  logic [DW-1:0]    in_a0     = '0;
  logic [DW-1:0]    in_a1     = '0;
  logic [DW-1:0]    in_b0     = '0;
  logic [DW-1:0]    in_b1     = '0;
  logic             res_ready = 1'b0;
  logic             busy;
  logic             in_ready;
  logic             res_valid;
  logic [DW-1:0]    res_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot_product_sequencer #(.LEN_W(LEN_W), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
`ifdef DPS_INIT_EN
    .init_acc  (init_acc),
`endif
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a0     (in_a0),
    .in_a1     (in_a1),
    .in_b0     (in_b0),
    .in_b1     (in_b1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] res;
  } vec_t;

  // Exact FP32 encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] fp_of_int(input int v);
    logic [31:0] mag;
    logic [31:0] frac;
    int          msb;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    frac = (mag << (23 - msb)) & 32'h007F_FFFF;
    return {(v < 0), 8'(127 + msb), frac[22:0]};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l, input logic [31:0] ia);
    start    = 1'b1;
    len      = l;
    init_acc = ia;
    tick();
    start    = 1'b0;
    len      = LEN_W'($urandom);  // must not be re-sampled
  endtask

  task automatic drive_beat(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] b0, input logic [31:0] b1);
    in_valid = 1'b1;
    in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1;
    tick();
    in_valid = 1'b0;
    in_a0 = $urandom; in_a1 = $urandom; in_b0 = $urandom; in_b1 = $urandom;
  endtask

  task automatic finish_job(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk1({name, "_idle_busy"}, busy, 1'b0);
    chk1({name, "_idle_resv"}, res_valid, 1'b0);
  endtask

  // Random job: integer operands so every FP result is exact; the model is the
  // plain integer dot product plus seed, encoded to FP32 at the end.
  task automatic rand_job(input int idx);
    int          l, sent, base, sum, stall;
    int          x0, x1, y0, y1;
    logic [31:0] held;
    l    = int'($urandom_range(0, 5));
    base = HAS_INIT ? int'($urandom_range(0, 40)) - 20 : 0;
    do_start(LEN_W'(l), fp_of_int(base));
    sum  = base;
    sent = 0;
    while (sent < l) begin
      chk1("rnd_in_ready", in_ready, 1'b1);
      chk1("rnd_no_resv", res_valid, 1'b0);
      if ($urandom_range(0, 3) != 0) begin
        x0 = int'($urandom_range(0, 16)) - 8;
        x1 = int'($urandom_range(0, 16)) - 8;
        y0 = int'($urandom_range(0, 16)) - 8;
        y1 = int'($urandom_range(0, 16)) - 8;
        sum = sum + x0 * y0 + x1 * y1;
        sent++;
        drive_beat(fp_of_int(x0), fp_of_int(x1), fp_of_int(y0), fp_of_int(y1));
      end else begin
        tick();
      end
    end
    chk1("rnd_res_valid", res_valid, 1'b1);
    chk1("rnd_in_ready_done", in_ready, 1'b0);
    chk32("rnd_res_data", res_data, fp_of_int(sum));
    held  = fp_of_int(sum);
    stall = int'($urandom_range(0, 3));
    for (int s = 0; s < stall; s++) begin
      start = $urandom_range(0, 1) != 0;
      tick();
      chk1("rnd_stall_valid", res_valid, 1'b1);
      chk32("rnd_stall_data", res_data, held);
    end
    start = 1'b0;
    finish_job("rnd");
    $display("rand job %0d: len=%0d seed=%0d sum=%0d exp=%h got=%h", idx, l, base, sum,
             held, res_data);
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h4130_0000};
    tbl[1] = '{FP_ONE,        32'h0000_0000, FP_ONE,        32'h0000_0000, FP_ONE};
    tbl[2] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4100_0000};
    tbl[3] = '{32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000};
    tbl[4] = '{32'h3FC0_0000, 32'h3F00_0000, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
    tbl[5] = '{32'h3F00_0000, 32'h3E80_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3EC0_0000};
    tbl[6] = '{32'h4040_0000, 32'hC000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000};
    tbl[7] = '{32'hC000_0000, 32'hC040_0000, 32'h4040_0000, 32'h3F80_0000, 32'hC110_0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk32("rst_res_data", res_data, 32'h0);
    #3 rst_n = 1'b1;
    tick();

    // Table-driven single-beat jobs
    for (int k = 0; k < 8; k++) begin
      do_start(LEN_W'(1), FP_ZERO);
      chk1("tbl_busy", busy, 1'b1);
      chk1("tbl_in_ready", in_ready, 1'b1);
      drive_beat(tbl[k].a0, tbl[k].a1, tbl[k].b0, tbl[k].b1);
      chk1("tbl_res_valid", res_valid, 1'b1);
      chk32("tbl_res_data", res_data, tbl[k].res);
      $display("vec %0d: a=(%h,%h) b=(%h,%h) exp=%h got=%h", k, tbl[k].a0, tbl[k].a1,
               tbl[k].b0, tbl[k].b1, tbl[k].res, res_data);
      finish_job("tbl");
    end

    // Two beats with in_valid gaps (junk operands during gaps), then backpressure
    do_start(LEN_W'(2), FP_ZERO);
    drive_beat(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    for (int g = 0; g < 3; g++) begin
      tick();
      chk1("gap_in_ready", in_ready, 1'b1);
      chk1("gap_res_valid", res_valid, 1'b0);
    end
    drive_beat(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    chk1("two_res_valid", res_valid, 1'b1);
    chk32("two_res_data", res_data, 32'h41B0_0000);
    for (int s = 0; s < 5; s++) begin
      start = 1'b1;
      len   = LEN_W'(3);
      tick();
      chk1("bp_res_valid", res_valid, 1'b1);
      chk1("bp_busy", busy, 1'b1);
      chk32("bp_res_data", res_data, 32'h41B0_0000);
    end
    // start together with res_ready in DONE: only the handshake completes
    start     = 1'b1;
    res_ready = 1'b1;
    tick();
    start     = 1'b0;
    res_ready = 1'b0;
    chk1("bp_start_ignored_busy", busy, 1'b0);
    chk1("bp_start_ignored_inr", in_ready, 1'b0);
    chk32("bp_acc_kept", res_data, 32'h41B0_0000);
    $display("two-beat job with gaps and backpressure: got=%h", res_data);

    // Zero-length job
    do_start(LEN_W'(0), FP_ZERO);
    chk1("len0_in_ready", in_ready, 1'b0);
    chk1("len0_res_valid", res_valid, 1'b1);
    chk32("len0_res_data", res_data, 32'h0);
    finish_job("len0");
    $display("zero-length job: got=%h", res_data);

    // Async reset in the middle of a 4-beat job
    do_start(LEN_W'(4), FP_ZERO);
    drive_beat(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    drive_beat(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_in_ready", in_ready, 1'b0);
    chk1("arst_res_valid", res_valid, 1'b0);
    chk32("arst_res_data", res_data, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    do_start(LEN_W'(1), FP_ZERO);
    drive_beat(FP_ONE, 32'h0, FP_ONE, 32'h0);
    chk1("post_rst_valid", res_valid, 1'b1);
    chk32("post_rst_data", res_data, FP_ONE);
    finish_job("post_rst");
    $display("post-reset job: got=%h", res_data);

`ifdef DPS_INIT_EN
    do_start(LEN_W'(1), 32'h40A0_0000);
    drive_beat(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
    chk32("init_res_data", res_data, 32'h4180_0000);
    finish_job("init");
    do_start(LEN_W'(0), 32'h40A0_0000);
    chk32("init_len0_data", res_data, 32'h40A0_0000);
    finish_job("init_len0");
    $display("init_acc jobs done: last got=%h", res_data);
`endif

    // Randomized jobs against the integer model
    for (int j = 0; j < 30; j++) rand_job(j);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
